// File: rtl/adc_spi_slv_pkg.sv
// Shared definitions for the ADC configuration SPI responder: FSM states,
// frame geometry and the position of the write flag in the address byte.
package adc_spi_slv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_HOLD
  } spi_state_t;

  localparam int ADDR_BITS   = 8;
  localparam int DATA_BITS   = 16;
  localparam int FRAME_BITS  = ADDR_BITS + DATA_BITS;
  localparam int WR_FLAG_BIT = 7;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for one SPI pin followed by a registered edge
// detector. level, rise and fall all change on the same clk edge, three
// clk edges after the pin change is first sampled.
module spi_pin_sync (
  input  logic clk,
  input  logic sys_rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;

  // Reset to 0 so a chip select already low at reset release produces no
  // falling edge; the frame in progress is then ignored.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      meta  <= pin;
      sync  <= meta;
      level <= sync;
      rise  <= sync & ~level;
      fall  <= ~sync & level;
    end
  end

endmodule

// File: rtl/adc_spi_slave_regfile.sv
// SPI responder for 24-bit ADC configuration frames (rw + 7-bit address,
// 16-bit data) backed by a fabric register file. All pins are oversampled
// in the clk domain. The read-back path (MISO shift-out and rd_strobe) is
// built only when ADC_SPI_SLV_READBACK_EN is defined.
module adc_spi_slave_regfile
  import adc_spi_slv_pkg::*;
#(
  parameter int         NUM_REGS    = 32,
  parameter logic [6:0] STATUS_ADDR = 7'h12
) (
  input  logic                   clk,
  input  logic                   sys_rst_n,
  input  logic                   spi_sclk,
  input  logic                   spi_csb,
  input  logic                   spi_mosi,
  output logic                   spi_miso,
  input  logic [15:0]            status_in,
  output logic [NUM_REGS*16-1:0] reg_q,
  output logic                   wr_strobe,
  output logic [6:0]             wr_addr,
  output logic [15:0]            wr_data,
  output logic                   rd_strobe,
  output logic                   frame_err
);

  localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic csb_lvl, csb_rise, csb_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_pin_sync u_sync_sclk (.clk(clk), .sys_rst_n(sys_rst_n), .pin(spi_sclk),
                            .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_pin_sync u_sync_csb  (.clk(clk), .sys_rst_n(sys_rst_n), .pin(spi_csb),
                            .level(csb_lvl), .rise(csb_rise), .fall(csb_fall));
  spi_pin_sync u_sync_mosi (.clk(clk), .sys_rst_n(sys_rst_n), .pin(spi_mosi),
                            .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

  spi_state_t  state;
  logic [4:0]  bit_cnt;
  logic [15:0] sin;
  logic        rw;
  logic [6:0]  addr;
  logic [6:0]  rd_addr;
  logic        addr_done;
  logic        wr_pend;
  logic        wr_ok;
  logic [15:0] regs [NUM_REGS];

  // rd_addr is the address byte as it completes on the 8th SCLK rise
  assign rd_addr   = {sin[5:0], mosi_lvl};
  assign addr_done = (state == ST_ADDR) && !csb_rise && sclk_rise &&
                     (bit_cnt == 5'(ADDR_BITS - 1));
  assign wr_ok     = ({1'b0, addr} < NUM_REGS_W) && (addr != STATUS_ADDR);

  // Frame sequencing: count SCLK rises, shift MOSI in, flag aborts and
  // request a commit once a full write frame has been received.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      sin       <= '0;
      rw        <= 1'b0;
      addr      <= '0;
      wr_pend   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_pend   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (csb_fall) begin
            state   <= ST_ADDR;
            bit_cnt <= '0;
          end
        end
        ST_ADDR: begin
          if (csb_rise) begin
            state     <= ST_IDLE;
            frame_err <= 1'b1;
          end else if (sclk_rise) begin
            sin     <= {sin[14:0], mosi_lvl};
            bit_cnt <= bit_cnt + 5'd1;
            if (addr_done) begin
              // sin[6] holds bit 7 of the address byte until this shift
              rw    <= sin[WR_FLAG_BIT-1];
              addr  <= rd_addr;
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          // A CSB rise coinciding with the last SCLK rise still completes
          if (sclk_rise && (bit_cnt == 5'(FRAME_BITS - 1))) begin
            sin     <= {sin[14:0], mosi_lvl};
            bit_cnt <= bit_cnt + 5'd1;
            state   <= ST_HOLD;
            wr_pend <= rw;
          end else if (csb_rise) begin
            state     <= ST_IDLE;
            frame_err <= 1'b1;
          end else if (sclk_rise) begin
            sin     <= {sin[14:0], mosi_lvl};
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        ST_HOLD: begin
          if (csb_rise) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Commit a completed write one clk after the last bit; writes to the
  // status address or beyond the register file are silently dropped.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_strobe <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (wr_pend && wr_ok) begin
        regs[addr[AW-1:0]] <= sin;
        wr_addr            <= addr;
        wr_data            <= sin;
        wr_strobe          <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign reg_q[16*k +: 16] = regs[k];
  end

`ifdef ADC_SPI_SLV_READBACK_EN
  logic [15:0] sout;
  logic [15:0] rd_word;

  // Read source: live status overrides the register at STATUS_ADDR
  always_comb begin
    rd_word = 16'h0000;
    if (rd_addr == STATUS_ADDR) rd_word = status_in;
    else if ({1'b0, rd_addr} < NUM_REGS_W) rd_word = regs[rd_addr[AW-1:0]];
  end

  // Shift-out: load on the last address bit, then advance on every SCLK
  // fall except the one right after loading so bit 15 meets the 9th rise.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sout      <= '0;
      rd_strobe <= 1'b0;
      spi_miso  <= 1'b0;
    end else begin
      rd_strobe <= 1'b0;
      if (addr_done && !sin[WR_FLAG_BIT-1]) begin
        sout      <= rd_word;
        rd_strobe <= 1'b1;
      end else if ((state == ST_DATA) && sclk_fall &&
                   (bit_cnt != 5'(ADDR_BITS))) begin
        sout <= {sout[14:0], 1'b0};
      end
      spi_miso <= ((state == ST_DATA) && !rw) ? sout[15] : 1'b0;
    end
  end

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, csb_lvl, mosi_rise, mosi_fall};
`else
  assign spi_miso  = 1'b0;
  assign rd_strobe = 1'b0;

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, sclk_fall, csb_lvl, mosi_rise, mosi_fall,
                         status_in};
`endif

endmodule
